// File: rtl/morse_tx_sequencer.sv
// Morse transmitter: accepts ASCII characters over valid/ready and sequences
// dot/dash/gap timing on a single serial line, scaled by a latched dot period.
module morse_tx_sequencer #(
    parameter int PERIOD_WIDTH = 28
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [7:0]              char_i,
    input  logic                    char_valid_i,
    output logic                    char_ready_o,
    input  logic [PERIOD_WIDTH-1:0] dot_period_i,
    output logic                    morse_o,
    output logic                    busy_o,
    output logic                    unknown_o,
    output logic                    dot_period_error_o
);
    localparam int CW = PERIOD_WIDTH + 2;
    localparam logic [CW-1:0] ONE = 1;

    typedef enum logic [2:0] {IDLE, MARK, ELEM_GAP, CHAR_GAP, WORD_GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, p_q, p_d, p3_q, p3_d;
    logic [4:0]    pat_q, pat_d;
    logic [2:0]    rem_q, rem_d;
    logic          ready_q, ready_d, morse_q, morse_d, busy_q, busy_d;
    logic          unk_q, unk_d, perr_q, perr_d;

    logic [7:0]    code;
    logic [2:0]    code_len;
    logic [4:0]    code_pat, pat_al;
    logic [CW-1:0] p_in, p3_in, p4_in;
    logic          accept, is_space;

    // Returns {length, pattern}; pattern is right-aligned, first element in
    // the highest used bit, 1 = dash. Length 0 means no code.
    function automatic logic [7:0] lookup(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
        case (u)
            "A": return {3'd2, 5'b00001};  "B": return {3'd4, 5'b01000};
            "C": return {3'd4, 5'b01010};  "D": return {3'd3, 5'b00100};
            "E": return {3'd1, 5'b00000};  "F": return {3'd4, 5'b00010};
            "G": return {3'd3, 5'b00110};  "H": return {3'd4, 5'b00000};
            "I": return {3'd2, 5'b00000};  "J": return {3'd4, 5'b00111};
            "K": return {3'd3, 5'b00101};  "L": return {3'd4, 5'b00100};
            "M": return {3'd2, 5'b00011};  "N": return {3'd2, 5'b00010};
            "O": return {3'd3, 5'b00111};  "P": return {3'd4, 5'b00110};
            "Q": return {3'd4, 5'b01101};  "R": return {3'd3, 5'b00010};
            "S": return {3'd3, 5'b00000};  "T": return {3'd1, 5'b00001};
            "U": return {3'd3, 5'b00001};  "V": return {3'd4, 5'b00001};
            "W": return {3'd3, 5'b00011};  "X": return {3'd4, 5'b01001};
            "Y": return {3'd4, 5'b01011};  "Z": return {3'd4, 5'b01100};
            "0": return {3'd5, 5'b11111};  "1": return {3'd5, 5'b01111};
            "2": return {3'd5, 5'b00111};  "3": return {3'd5, 5'b00011};
            "4": return {3'd5, 5'b00001};  "5": return {3'd5, 5'b00000};
            "6": return {3'd5, 5'b10000};  "7": return {3'd5, 5'b11000};
            "8": return {3'd5, 5'b11100};  "9": return {3'd5, 5'b11110};
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        code     = lookup(char_i);
        code_len = code[7:5];
        code_pat = code[4:0];
        // Left-align so the element being sent is always bit 4.
        pat_al   = code_pat << (3'd5 - code_len);
        is_space = (char_i == 8'h20);
        accept   = char_valid_i & ready_q;
        p_in     = {2'b00, dot_period_i};
        p3_in    = p_in + {p_in[CW-2:0], 1'b0};
        p4_in    = {p_in[CW-3:0], 2'b00};

        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        p3_d    = p3_q;
        pat_d   = pat_q;
        rem_d   = rem_q;
        ready_d = ready_q;
        morse_d = morse_q;
        busy_d  = busy_q;
        unk_d   = 1'b0;
        perr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                morse_d = 1'b0;
                if (accept) begin
                    if (dot_period_i == '0) begin
                        perr_d = 1'b1;
                    end else if (is_space) begin
                        state_d = WORD_GAP;
                        ready_d = 1'b0;
                        busy_d  = 1'b1;
                        cnt_d   = p4_in - ONE;
                        p_d     = p_in;
                        p3_d    = p3_in;
                    end else if (code_len == 3'd0) begin
                        unk_d = 1'b1;
                    end else begin
                        state_d = MARK;
                        ready_d = 1'b0;
                        busy_d  = 1'b1;
                        morse_d = 1'b1;
                        cnt_d   = (pat_al[4] ? p3_in : p_in) - ONE;
                        pat_d   = pat_al << 1;
                        rem_d   = code_len - 3'd1;
                        p_d     = p_in;
                        p3_d    = p3_in;
                    end
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    case (state_q)
                        MARK: begin
                            morse_d = 1'b0;
                            if (rem_q != 3'd0) begin
                                state_d = ELEM_GAP;
                                cnt_d   = p_q - ONE;
                            end else begin
                                state_d = CHAR_GAP;
                                cnt_d   = p3_q - ONE;
                            end
                        end
                        ELEM_GAP: begin
                            state_d = MARK;
                            morse_d = 1'b1;
                            cnt_d   = (pat_q[4] ? p3_q : p_q) - ONE;
                            pat_d   = pat_q << 1;
                            rem_d   = rem_q - 3'd1;
                        end
                        default: begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            ready_d = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            p3_q    <= '0;
            pat_q   <= '0;
            rem_q   <= '0;
            ready_q <= 1'b0;
            morse_q <= 1'b0;
            busy_q  <= 1'b0;
            unk_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            p3_q    <= p3_d;
            pat_q   <= pat_d;
            rem_q   <= rem_d;
            ready_q <= ready_d;
            morse_q <= morse_d;
            busy_q  <= busy_d;
            unk_q   <= unk_d;
            perr_q  <= perr_d;
        end
    end

    assign char_ready_o       = ready_q;
    assign morse_o            = morse_q;
    assign busy_o             = busy_q;
    assign unknown_o          = unk_q;
    assign dot_period_error_o = perr_q;
endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Scoreboard bench for morse_tx_sequencer: a text-level Morse model predicts
// every output cycle; a monitor compares the DUT against the queued prediction.
module tb_morse_tx_sequencer;
    localparam int PW = 28;
    // Expected output vector {morse, busy, ready, unknown, period_error}.
    localparam logic [4:0] E_IDLE = 5'b00100, E_MARK = 5'b11000, E_LOW = 5'b01000;
    localparam logic [4:0] E_UNK  = 5'b00110, E_PERR = 5'b00101;

    logic          clk = 1'b0, rst = 1'b1;
    logic [7:0]    char_i = 8'h00;
    logic          char_valid_i = 1'b0;
    logic [PW-1:0] dot_period_i = '0;
    logic          char_ready_o, morse_o, busy_o, unknown_o, dot_period_error_o;

    morse_tx_sequencer #(.PERIOD_WIDTH(PW)) dut (
        .clk_i(clk), .rst_i(rst), .char_i(char_i), .char_valid_i(char_valid_i),
        .char_ready_o(char_ready_o), .dot_period_i(dot_period_i), .morse_o(morse_o),
        .busy_o(busy_o), .unknown_o(unknown_o), .dot_period_error_o(dot_period_error_o)
    );

    always #5 clk = ~clk;

    logic [4:0] exp_q[$];
    int  checks = 0, passes = 0;
    bit  mon_en = 1'b0;

    function automatic logic [4:0] outs();
        return {morse_o, busy_o, char_ready_o, unknown_o, dot_period_error_o};
    endfunction

    function automatic string morse_of(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
        case (u)
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
            "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
            "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
            "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
            "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
            "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
            "8": return "---.."; "9": return "----.";
            " ": return " ";
            default: return "?";
        endcase
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s t=%0t got m/b/r/u/e=%b expected %b", name, $time, act, req);
    endtask

    // Expected per-cycle outputs, starting the cycle after the accept edge.
    task automatic push_expect(input logic [7:0] c, input int p);
        string s;
        s = morse_of(c);
        if (p == 0) exp_q.push_back(E_PERR);
        else if (s == "?") exp_q.push_back(E_UNK);
        else if (s == " ") repeat (4 * p) exp_q.push_back(E_LOW);
        else begin
            for (int i = 0; i < s.len(); i++) begin
                repeat ((s[i] == "-") ? 3 * p : p) exp_q.push_back(E_MARK);
                if (i < s.len() - 1) repeat (p) exp_q.push_back(E_LOW);
            end
            repeat (3 * p) exp_q.push_back(E_LOW);
        end
    endtask

    // Presents the character in the first cycle the DUT is ready; the accept
    // happens at the following rising edge.
    task automatic send(input logic [7:0] c, input int p);
        int n;
        n = 0;
        @(negedge clk);
        while (!char_ready_o && n < 5000) begin
            char_valid_i = 1'b0;
            dot_period_i = PW'($urandom);
            char_i       = 8'($urandom);
            @(negedge clk);
            n++;
        end
        if (!char_ready_o) begin
            checks++;
            $display("FAIL ready_timeout t=%0t char_ready_o=0 required 1", $time);
            char_valid_i = 1'b0;
        end else begin
            char_i       = c;
            dot_period_i = PW'(p);
            char_valid_i = 1'b1;
            push_expect(c, p);
        end
    endtask

    always begin : monitor
        logic [4:0] e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : E_IDLE;
            chk("cycle_outputs", outs(), e);
        end
    end

    initial begin : stim
        string pool;
        int n;
        pool = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789 #?!@";
        #12;
        chk("reset_values", outs(), 5'b00000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("first_cycle_ready", outs(), E_IDLE);
        mon_en = 1'b1;

        send("E", 4);
        send("a", 2);
        send("A", 2);
        send("0", 1);
        send(" ", 1);
        send("7", 1);
        send("#", 5);
        send("T", 5);
        send("S", 0);
        send("S", 3);

        send("O", 8);
        @(negedge clk);
        char_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("reset_mid_dash", outs(), 5'b00000);
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("reset_held", outs(), 5'b00000);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", outs(), E_IDLE);
        mon_en = 1'b1;
        send("E", 4);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                char_valid_i = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            send(pool[$urandom_range(0, pool.len() - 1)], $urandom_range(0, 4));
        end

        @(negedge clk);
        char_valid_i = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout t=%0t pending=%0d required 0", $time, exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
